timing_sequencer: RTL and testbench

Generates the one-hot phase strobes `t0`–`t5` that drive `control_unit`, sitting between the run/step controls and the control unit's phase inputs. It advances one phase per clock and shortens each instruction to its real length from the fetched opcode. It stops the machine on HALT and counts completed instructions for debug. It optionally supports single-instruction stepping.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/seq_len_decode.sv | 22 ++
 rtl/timing_sequencer.sv | 141 ++++++++++++++
 tb/tb_timing_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, sequencer states and phase-length constants.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam logic [3:0] OP_MOV  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [3:0] OP_OUT  = 4'b1110;
    localparam logic [3:0] OP_JGT  = 4'b0110;
    localparam logic [3:0] OP_JMP  = 4'b0111;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Index of the final phase strobe for each instruction class.
    localparam logic [2:0] PH_LONG  = 3'd5;
    localparam logic [2:0] PH_SHORT = 3'd3;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_HALT  = 2'd2,
        SEQ_PAUSE = 2'd3
    } seq_state_t;

    function automatic logic [5:0] phase_onehot(input logic [2:0] ph);
        return 6'b000001 << ph;
    endfunction

endpackage

// File: rtl/seq_len_decode.sv
// Maps an opcode to its final phase index and flags HALT.
// Latency: combinational.
// Backpressure: none.
module seq_len_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] t_last,
    output logic       is_halt
);

    always_comb begin
        t_last  = PH_SHORT;
        is_halt = 1'b0;
        case (opcode)
            OP_MOV, OP_ADD, OP_SUB, OP_JGT: t_last  = PH_LONG;
            OP_HALT:                        is_halt = 1'b1;
            default:                        t_last  = PH_SHORT;
        endcase
    end

endmodule

// File: rtl/timing_sequencer.sv
// One-hot phase strobe generator t0..t5 with per-opcode length, HALT stop and instruction counter.
// Latency: run sampled in IDLE -> t0 next cycle; back-to-back instructions with no bubble.
// Backpressure: run / step gating only at instruction boundaries; TSEQ_SINGLE_STEP_EN adds PAUSE stepping.
module timing_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             step_mode,
    input  logic             step_req,
    output logic             t0,
    output logic             t1,
    output logic             t2,
    output logic             t3,
    output logic             t4,
    output logic             t5,
    output logic             instr_done,
    output logic             halted,
    output logic             paused,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_t state;
    logic [2:0] phase;
    logic [2:0] phase_nxt;
    logic [5:0] strobe;
    logic [3:0] op_lat;
    logic [3:0] dec_op;
    logic [2:0] dec_t_last;
    logic       dec_halt;
    logic       paused_r;
    logic       step_en;
    logic       step_go;

`ifdef TSEQ_SINGLE_STEP_EN
    assign step_en = step_mode;
    assign step_go = step_req | ~step_mode;
    assign paused  = paused_r;
`else
    logic unused_step;
    assign step_en     = 1'b0;
    assign step_go     = 1'b0;
    assign paused      = 1'b0;
    assign unused_step = step_mode ^ step_req ^ paused_r;
`endif

    // During t2 the live opcode decides the t2->t3 step; later phases use the latched copy.
    assign dec_op    = (phase == 3'd2) ? opcode : op_lat;
    assign phase_nxt = phase + 3'd1;

    seq_len_decode u_len (
        .opcode  (dec_op),
        .t_last  (dec_t_last),
        .is_halt (dec_halt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= SEQ_IDLE;
            phase      <= 3'd0;
            strobe     <= 6'b0;
            op_lat     <= 4'b0;
            instr_done <= 1'b0;
            halted     <= 1'b0;
            paused_r   <= 1'b0;
            instr_cnt  <= '0;
        end else begin
            instr_done <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (run && step_en) begin
                        state    <= SEQ_PAUSE;
                        paused_r <= 1'b1;
                    end else if (run) begin
                        state  <= SEQ_RUN;
                        phase  <= 3'd0;
                        strobe <= phase_onehot(3'd0);
                    end
                end
                SEQ_RUN: begin
                    if (phase == 3'd2) begin
                        op_lat <= opcode;
                    end
                    if (phase == 3'd2 && dec_halt) begin
                        state  <= SEQ_HALT;
                        strobe <= 6'b0;
                        halted <= 1'b1;
                    end else if (instr_done) begin
                        // instr_done marks the current cycle as t_last: instruction boundary.
                        phase <= 3'd0;
                        if (!run) begin
                            state  <= SEQ_IDLE;
                            strobe <= 6'b0;
                        end else if (step_en) begin
                            state    <= SEQ_PAUSE;
                            strobe   <= 6'b0;
                            paused_r <= 1'b1;
                        end else begin
                            strobe <= phase_onehot(3'd0);
                        end
                    end else begin
                        phase  <= phase_nxt;
                        strobe <= phase_onehot(phase_nxt);
                        if (phase_nxt == dec_t_last) begin
                            instr_done <= 1'b1;
                            instr_cnt  <= instr_cnt + CNT_ONE;
                        end
                    end
                end
                SEQ_PAUSE: begin
                    if (!run) begin
                        state    <= SEQ_IDLE;
                        paused_r <= 1'b0;
                    end else if (step_go) begin
                        state    <= SEQ_RUN;
                        phase    <= 3'd0;
                        strobe   <= phase_onehot(3'd0);
                        paused_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign t0 = strobe[0];
    assign t1 = strobe[1];
    assign t2 = strobe[2];
    assign t3 = strobe[3];
    assign t4 = strobe[4];
    assign t5 = strobe[5];

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed scoreboard bench for timing_sequencer; step-mode section depends on TSEQ_SINGLE_STEP_EN.
module tb_timing_sequencer;

    localparam int CNT_W = 8;
    localparam logic [5:0] NO_T = 6'b0;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic [3:0]       opcode;
    logic             step_mode;
    logic             step_req;
    logic             t0, t1, t2, t3, t4, t5;
    logic             instr_done;
    logic             halted;
    logic             paused;
    logic [CNT_W-1:0] instr_cnt;

    typedef logic [6+3+CNT_W-1:0] obs_t;

    obs_t       exp_q[$];
    string      tag_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [CNT_W-1:0] exp_cnt;

    timing_sequencer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .opcode     (opcode),
        .step_mode  (step_mode),
        .step_req   (step_req),
        .t0         (t0),
        .t1         (t1),
        .t2         (t2),
        .t3         (t3),
        .t4         (t4),
        .t5         (t5),
        .instr_done (instr_done),
        .halted     (halted),
        .paused     (paused),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] oh(input int p);
        return 6'b000001 << p;
    endfunction

    // Push the expected outputs for the next cycle, advance one edge, pop and compare.
    task automatic cyc(input string tag, input logic [5:0] t, input logic done,
                       input logic hlt, input logic pau);
        obs_t  e;
        obs_t  o;
        string tg;
        if (done) exp_cnt = exp_cnt + 1'b1;
        exp_q.push_back({t, done, hlt, pau, exp_cnt});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        o  = {t5, t4, t3, t2, t1, t0, instr_done, halted, paused, instr_cnt};
        e  = exp_q.pop_front();
        tg = tag_q.pop_front();
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tg, o, e);
        end
    endtask

    // Called while t0 is showing; runs the instruction through its final phase.
    task automatic do_instr(input string tag, input logic [3:0] op,
                            input bit drop_t1, input bit step_t2);
        int last;
        last = (op == 4'h0 || op == 4'h3 || op == 4'hC || op == 4'h6) ? 5 : 3;
        opcode = op;
        cyc({tag, "_t1"}, oh(1), 1'b0, 1'b0, 1'b0);
        if (drop_t1) run = 1'b0;
        cyc({tag, "_t2"}, oh(2), 1'b0, 1'b0, 1'b0);
        if (step_t2) step_req = 1'b1;
        if (op == 4'hF) begin
            cyc({tag, "_halt"}, NO_T, 1'b0, 1'b1, 1'b0);
            step_req = 1'b0;
            return;
        end
        cyc({tag, "_t3"}, oh(3), last == 3, 1'b0, 1'b0);
        step_req = 1'b0;
        opcode   = 4'($urandom_range(0, 15));
        for (int p = 4; p <= last; p++) begin
            cyc({tag, "_tl"}, oh(p), p == last, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; opcode = 4'h0; step_mode = 1'b0; step_req = 1'b0;
        exp_cnt = '0;
        cyc("rst0", NO_T, 1'b0, 1'b0, 1'b0);
        cyc("rst1", NO_T, 1'b0, 1'b0, 1'b0);

        reset = 1'b1; run = 1'b1; opcode = 4'h3;
        cyc("start", oh(0), 1'b0, 1'b0, 1'b0);
        do_instr("add", 4'h3, 1'b0, 1'b0);
        cyc("add_next", oh(0), 1'b0, 1'b0, 1'b0);
        do_instr("out", 4'hE, 1'b0, 1'b0);
        cyc("out_next", oh(0), 1'b0, 1'b0, 1'b0);
        do_instr("mov", 4'h0, 1'b0, 1'b0);
        cyc("mov_next", oh(0), 1'b0, 1'b0, 1'b0);

        do_instr("add_drop", 4'h3, 1'b1, 1'b0);
        cyc("idle0", NO_T, 1'b0, 1'b0, 1'b0);
        cyc("idle1", NO_T, 1'b0, 1'b0, 1'b0);
        run = 1'b1;
        cyc("restart", oh(0), 1'b0, 1'b0, 1'b0);
        do_instr("sub", 4'hC, 1'b0, 1'b0);
        cyc("sub_next", oh(0), 1'b0, 1'b0, 1'b0);
        do_instr("jgt", 4'h6, 1'b0, 1'b0);
        cyc("jgt_next", oh(0), 1'b0, 1'b0, 1'b0);
        do_instr("jmp", 4'h7, 1'b0, 1'b0);
        cyc("jmp_next", oh(0), 1'b0, 1'b0, 1'b0);
        do_instr("dflt", 4'h9, 1'b0, 1'b0);
        cyc("dflt_next", oh(0), 1'b0, 1'b0, 1'b0);

        do_instr("halt", 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run      = 1'b1;
            step_req = (i % 2 == 0);
            cyc("halt_hold", NO_T, 1'b0, 1'b1, 1'b0);
        end
        step_req = 1'b0;
        reset    = 1'b0;
        exp_cnt  = '0;
        cyc("halt_rst", NO_T, 1'b0, 1'b0, 1'b0);

        reset = 1'b1; run = 1'b1;
        cyc("wrap_start", oh(0), 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 256; n++) begin
            do_instr("wrap", 4'hE, 1'b0, 1'b0);
            cyc("wrap_next", oh(0), 1'b0, 1'b0, 1'b0);
        end

        opcode = 4'h0;
        for (int p = 1; p <= 4; p++) begin
            cyc("pre_rst", oh(p), 1'b0, 1'b0, 1'b0);
        end
        reset   = 1'b0;
        exp_cnt = '0;
        cyc("rst_t4", NO_T, 1'b0, 1'b0, 1'b0);

`ifdef TSEQ_SINGLE_STEP_EN
        reset = 1'b1; run = 1'b1; step_mode = 1'b1;
        cyc("pause_enter", NO_T, 1'b0, 1'b0, 1'b1);
        cyc("pause_hold", NO_T, 1'b0, 1'b0, 1'b1);
        step_req = 1'b1;
        cyc("step_go", oh(0), 1'b0, 1'b0, 1'b0);
        step_req = 1'b0;
        do_instr("step_out", 4'hE, 1'b0, 1'b1);
        cyc("pause_again", NO_T, 1'b0, 1'b0, 1'b1);
        step_req = 1'b1;
        cyc("step_go2", oh(0), 1'b0, 1'b0, 1'b0);
        step_req = 1'b0;
        do_instr("step_mov", 4'h0, 1'b0, 1'b0);
        cyc("pause_mov", NO_T, 1'b0, 1'b0, 1'b1);
        run = 1'b0;
        cyc("pause_idle", NO_T, 1'b0, 1'b0, 1'b0);
        run = 1'b1;
        cyc("pause_reenter", NO_T, 1'b0, 1'b0, 1'b1);
        step_mode = 1'b0;
        cyc("mode_off", oh(0), 1'b0, 1'b0, 1'b0);
        do_instr("free", 4'hE, 1'b0, 1'b0);
        cyc("free_next", oh(0), 1'b0, 1'b0, 1'b0);
`else
        reset = 1'b1; run = 1'b1; step_mode = 1'b1; step_req = 1'b1;
        cyc("nostep_start", oh(0), 1'b0, 1'b0, 1'b0);
        step_req = 1'b0;
        do_instr("nostep", 4'hE, 1'b0, 1'b1);
        cyc("nostep_next", oh(0), 1'b0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
